// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: memory-arbiter states, grant sources and line geometry.
package rv32i_types;

    localparam int ARB_LINE_W   = 256;
    localparam int ARB_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        ARB_I,
        ARB_D
    } arb_src_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache miss ports.
// Optional ARB_RR_EN: round-robin between the caches instead of fixed D-over-I priority.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W   = ARB_LINE_W,
    parameter int OFFSET_W = ARB_OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

    arb_state_t        state_q, state_d;
    arb_src_t          grant;
    logic              rd_d, wr_d, i_resp_d, d_resp_d;
    logic [31:0]       addr_d;
    logic [LINE_W-1:0] wdata_d, i_rdata_d, d_rdata_d;

    function automatic logic [31:0] line_align(input logic [31:0] a);
        return a & LINE_MASK;
    endfunction

`ifdef ARB_RR_EN
    arb_src_t last_grant_q, last_grant_d;

    // With both sides pending, the side not granted last wins.
    function automatic arb_src_t pick_src(input logic i_req, input logic d_req,
                                          input arb_src_t last);
        if (i_req && d_req)
            return (last == ARB_I) ? ARB_D : ARB_I;
        return d_req ? ARB_D : ARB_I;
    endfunction
`else
    function automatic arb_src_t pick_src(input logic d_req);
        return d_req ? ARB_D : ARB_I;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        grant     = ARB_I;
        rd_d      = pmem_read;
        wr_d      = pmem_write;
        addr_d    = pmem_addr;
        wdata_d   = pmem_wdata;
        i_resp_d  = 1'b0;
        d_resp_d  = 1'b0;
        i_rdata_d = i_rdata;
        d_rdata_d = d_rdata;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_read || d_read || d_write) begin
`ifdef ARB_RR_EN
                    grant        = pick_src(i_read, d_read || d_write, last_grant_q);
                    last_grant_d = grant;
`else
                    grant = pick_src(d_read || d_write);
`endif
                    if (grant == ARB_D) begin
                        state_d = SERVE_D;
                        addr_d  = line_align(d_addr);
                        // A simultaneous read and write-back is treated as the write-back.
                        if (d_write) begin
                            wr_d    = 1'b1;
                            wdata_d = d_wdata;
                        end else begin
                            rd_d = 1'b1;
                        end
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = line_align(i_addr);
                        rd_d    = 1'b1;
                    end
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_d   = RESP;
                    rd_d      = 1'b0;
                    i_rdata_d = pmem_rdata;
                    i_resp_d  = 1'b1;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_d = RESP;
                    if (pmem_read)
                        d_rdata_d = pmem_rdata;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    d_resp_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state_q    <= state_d;
            pmem_read  <= rd_d;
            pmem_write <= wr_d;
            pmem_addr  <= addr_d;
            pmem_wdata <= wdata_d;
            i_resp     <= i_resp_d;
            d_resp     <= d_resp_d;
            i_rdata    <= i_rdata_d;
            d_rdata    <= d_rdata_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant_q <= ARB_I;
        else
            last_grant_q <= last_grant_d;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (default build, fixed D-over-I priority): vector table plus
// hand sequences, with a memory responder and a queue-based scoreboard.
module tb_mem_arbiter;

    localparam int LW = 256;

    logic          clk, rst;
    logic          i_read, d_read, d_write, i_resp, d_resp;
    logic [31:0]   i_addr, d_addr, pmem_addr;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
    logic          pmem_read, pmem_write, pmem_resp;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          is_i;
        logic          d_rd;
        logic          d_wr;
        logic [31:0]   addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] line;
        int            lat;
        logic [31:0]   exp_addr;
        logic          chg;
    } vec_t;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [LW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic          is_i;
        logic [LW-1:0] rdata;
        int            lat;
    } rsp_t;

    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    vec_t vecs[7];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            mem_lat  = 3;
    logic          mem_en   = 1'b1;
    logic [LW-1:0] mem_line = '0;
    logic [LW-1:0] i_model  = '0;
    logic [LW-1:0] d_model  = '0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model: answers a held command after mem_lat cycles with mem_line.
    initial begin
        int cnt;
        cnt = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst || !mem_en) begin
                cnt = 0;
                if (!rst) pmem_resp = 1'b0;
            end else if ((pmem_read || pmem_write) && !pmem_resp) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem_line;
                    cnt        = 0;
                end
            end else begin
                pmem_resp = 1'b0;
            end
        end
    end

    // Scoreboard monitor: pops expected commands on command rise and expected responses on resp.
    initial begin
        logic          prev_cmd, cur_wr;
        logic [31:0]   cur_addr;
        logic [LW-1:0] cur_wdata;
        int            cmd_cycles;
        cmd_t          ec;
        rsp_t          er;
        prev_cmd = 1'b0; cur_wr = 1'b0; cur_addr = '0; cur_wdata = '0; cmd_cycles = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_cmd   = 1'b0;
                cmd_cycles = 0;
            end else begin
                check("rd_wr_exclusive", 256'(pmem_read & pmem_write), 256'(0));
                check("resp_exclusive", 256'(i_resp & d_resp), 256'(0));
                if ((pmem_read || pmem_write) && !prev_cmd) begin
                    if (exp_cmd.size() == 0) begin
                        check("unexpected_cmd", 256'(1), 256'(0));
                    end else begin
                        ec = exp_cmd.pop_front();
                        check("cmd_read", 256'(pmem_read), 256'(ec.rd));
                        check("cmd_write", 256'(pmem_write), 256'(ec.wr));
                        check("cmd_addr", 256'(pmem_addr), 256'(ec.addr));
                        if (ec.wr) check("cmd_wdata", pmem_wdata, ec.wdata);
                        cur_addr = ec.addr; cur_wr = ec.wr; cur_wdata = ec.wdata;
                    end
                end else if (pmem_read || pmem_write) begin
                    check("addr_hold", 256'(pmem_addr), 256'(cur_addr));
                    if (cur_wr) check("wdata_hold", pmem_wdata, cur_wdata);
                end
                if (pmem_read || pmem_write) cmd_cycles++;
                if (i_resp || d_resp) begin
                    if (exp_rsp.size() == 0) begin
                        check("unexpected_resp", 256'(1), 256'(0));
                    end else begin
                        er = exp_rsp.pop_front();
                        check("resp_side_i", 256'(i_resp), 256'(er.is_i));
                        check("resp_side_d", 256'(d_resp), 256'(!er.is_i));
                        check(er.is_i ? "i_rdata" : "d_rdata", er.is_i ? i_rdata : d_rdata, er.rdata);
                        check("cmd_cycles", 256'(cmd_cycles), 256'(er.lat));
                    end
                    cmd_cycles = 0;
                end
                prev_cmd = pmem_read || pmem_write;
            end
        end
    end

    task automatic push_txn(input logic is_i, input logic wr, input logic [31:0] ea,
                            input logic [LW-1:0] wd, input logic [LW-1:0] line, input int lat);
        exp_cmd.push_back('{rd: !wr, wr: wr, addr: ea, wdata: wd});
        if (is_i) i_model = line;
        else if (!wr) d_model = line;
        exp_rsp.push_back('{is_i: is_i, rdata: is_i ? i_model : d_model, lat: lat});
    endtask

    task automatic wait_resp(input logic want_i, input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (want_i ? i_resp : d_resp) break;
        end
        if (k == 200) check({name, "_timeout"}, 256'(1), 256'(0));
    endtask

    task automatic run_vec(input vec_t v);
        logic changed;
        int   k;
        changed = 1'b0;
        @(negedge clk);
        mem_lat  = v.lat;
        mem_line = v.line;
        push_txn(v.is_i, !v.is_i && v.d_wr, v.exp_addr, v.wdata, v.line, v.lat);
        if (v.is_i) begin
            i_read = 1'b1; i_addr = v.addr;
        end else begin
            d_read = v.d_rd; d_write = v.d_wr; d_addr = v.addr; d_wdata = v.wdata;
        end
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (v.chg && !changed && (pmem_read || pmem_write)) begin
                i_addr  = 32'h0000_2000;
                d_addr  = 32'h0000_0000;
                d_wdata = ~d_wdata;
                changed = 1'b1;
            end
            if (i_resp || d_resp) break;
        end
        if (k == 200) check("vec_timeout", 256'(1), 256'(0));
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    initial begin
        int gap, nd;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, '0, {8{32'hAAAA_AAAA}}, 3, 32'h0000_1220, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h8000_0040, {8{32'h5555_5555}}, '0, 3, 32'h8000_0040, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_007F, '0, {8{32'h0123_4567}}, 1, 32'h0000_0060, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, {4{64'hDEAD_BEEF_0BAD_F00D}}, {8{32'h7777_7777}}, 5, 32'hFFFF_FFE0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, '0, {8{32'h1357_9BDF}}, 4, 32'h0000_1220, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, '0, {8{32'hC0DE_CAFE}}, 2, 32'hDEAD_BEE0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, '0, {8{32'h2468_ACE0}}, 2, 32'h0000_0100, 1'b0};

        rst = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_pmem_read", 256'(pmem_read), 256'(0));
        check("rst_pmem_write", 256'(pmem_write), 256'(0));
        check("rst_pmem_addr", 256'(pmem_addr), 256'(0));
        check("rst_pmem_wdata", pmem_wdata, '0);
        check("rst_resp", 256'({i_resp, d_resp}), 256'(0));
        check("rst_rdata", i_rdata | d_rdata, '0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Contention: D wins, I follows two cycles after d_resp.
        @(negedge clk);
        mem_lat = 2; mem_line = {8{32'h0F0F_0F0F}};
        push_txn(1'b0, 1'b0, 32'h0000_4000, '0, {8{32'h0F0F_0F0F}}, 2);
        push_txn(1'b1, 1'b0, 32'h0000_5020, '0, {8{32'hF0F0_F0F0}}, 2);
        d_read = 1'b1; d_addr = 32'h0000_4010;
        i_read = 1'b1; i_addr = 32'h0000_503C;
        wait_resp(1'b0, "contend_d");
        d_read = 1'b0;
        mem_line = {8{32'hF0F0_F0F0}};
        gap = 0;
        while (!pmem_read && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        check("contend_i_grant_gap", 256'(gap), 256'(2));
        wait_resp(1'b1, "contend_i");
        i_read = 1'b0;

        // Fixed priority: D held for three transactions starves I until it drops.
        @(negedge clk);
        mem_lat = 1; mem_line = {8{32'h3C3C_3C3C}};
        for (int i = 0; i < 3; i++)
            push_txn(1'b0, 1'b0, 32'h0000_6000, '0, {8{32'h3C3C_3C3C}}, 1);
        push_txn(1'b1, 1'b0, 32'h0000_7000, '0, {8{32'h3C3C_3C3C}}, 1);
        d_read = 1'b1; d_addr = 32'h0000_6004;
        i_read = 1'b1; i_addr = 32'h0000_7008;
        nd = 0;
        for (int k = 0; k < 200 && nd < 3; k++) begin
            @(negedge clk);
            if (d_resp) nd++;
        end
        check("fixed_prio_d_count", 256'(nd), 256'(3));
        d_read = 1'b0;
        wait_resp(1'b1, "fixed_prio_i");
        i_read = 1'b0;

        // Stray pmem_resp in IDLE must not produce a response.
        @(negedge clk);
        mem_en = 1'b0;
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_resp_ignored", 256'({i_resp, d_resp, pmem_read, pmem_write}), 256'(0));
        mem_en = 1'b1;

        // Reset in the middle of a D read.
        @(negedge clk);
        mem_lat = 1000;
        exp_cmd.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h1000_0000, wdata: '0});
        d_read = 1'b1; d_addr = 32'h1000_0008;
        for (int k = 0; k < 20 && !pmem_read; k++) @(negedge clk);
        check("midop_cmd_started", 256'(pmem_read), 256'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midop_async_read", 256'(pmem_read), 256'(0));
        check("midop_async_addr", 256'(pmem_addr), 256'(0));
        check("midop_async_rdata", i_rdata | d_rdata, '0);
        i_model = '0; d_model = '0;
        d_read = 1'b0;
        repeat (2) @(negedge clk);
        check("midop_no_resp", 256'({i_resp, d_resp}), 256'(0));
        rst = 1'b1;
        run_vec(vecs[6]);

        repeat (4) @(negedge clk);
        check("cmd_queue_empty", 256'(exp_cmd.size()), 256'(0));
        check("rsp_queue_empty", 256'(exp_rsp.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
